mem_wb_stage: RTL and testbench

//  MEM/WB pipeline register plus writeback formatting for the 5-stage MIPS core.

---
 rtl/mem_wb_stage.sv | 146 ++++++++++++++
 tb/tb_mem_wb_stage.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_wb_stage                                                  |
// | Purpose  : MEM/WB pipeline register with writeback formatting for the    |
// |            5-stage MIPS core. Extracts/extends load data, selects the    |
// |            writeback value, drives the register-file write port and WB   |
// |            forwarding path one cycle after MEM. Also keeps a retired-    |
// |            instruction counter and a sticky illegal-wbsel error flag.    |
// | Ports    : clk, reset (async, active-low), stall, flush                  |
// |            m_valid, m_pc, m_alu, m_rdata, m_addr_lo, m_wr, m_regwrite,   |
// |            m_wbsel, m_ldtype            -- MEM-stage inputs              |
// |            w_we, w_wr, w_wd, w_pc, w_valid -- WB-stage / RF write port   |
// |            retired_count, wb_err        -- status                        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module mem_wb_stage #(
  parameter int          COUNT_W     = 32,
  parameter logic [31:0] LINK_OFFSET = 32'd8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               m_valid,
  input  logic [31:0]        m_pc,
  input  logic [31:0]        m_alu,
  input  logic [31:0]        m_rdata,
  input  logic [1:0]         m_addr_lo,
  input  logic [4:0]         m_wr,
  input  logic               m_regwrite,
  input  logic [1:0]         m_wbsel,
  input  logic [2:0]         m_ldtype,
  output logic               w_we,
  output logic [4:0]         w_wr,
  output logic [31:0]        w_wd,
  output logic [31:0]        w_pc,
  output logic               w_valid,
  output logic [COUNT_W-1:0] retired_count,
  output logic               wb_err
);

  localparam logic [1:0] C_WB_ALU  = 2'b00;
  localparam logic [1:0] C_WB_LOAD = 2'b01;
  localparam logic [1:0] C_WB_LINK = 2'b10;
  localparam logic [1:0] C_WB_ILL  = 2'b11;

  localparam logic [2:0] C_LD_LH  = 3'b001;
  localparam logic [2:0] C_LD_LHU = 3'b010;
  localparam logic [2:0] C_LD_LB  = 3'b011;
  localparam logic [2:0] C_LD_LBU = 3'b100;

  localparam logic [COUNT_W-1:0] C_ONE = COUNT_W'(1);

  logic [15:0] w_half;
  logic [7:0]  w_byte;
  logic [31:0] w_load;
  logic [31:0] w_fmt;
  logic        w_we_next;
  logic        w_capture;

  logic               r_we;
  logic [4:0]         r_wr;
  logic [31:0]        r_wd;
  logic [31:0]        r_pc;
  logic               r_valid;
  logic [COUNT_W-1:0] r_count;
  logic               r_err;

  // Halfword select ignores addr_lo[0]: misaligned halfwords are not trapped.
  assign w_half = m_addr_lo[1] ? m_rdata[31:16] : m_rdata[15:0];

  always_comb begin
    w_byte = m_rdata[7:0];
    case (m_addr_lo)
      2'd1:    w_byte = m_rdata[15:8];
      2'd2:    w_byte = m_rdata[23:16];
      2'd3:    w_byte = m_rdata[31:24];
      default: w_byte = m_rdata[7:0];
    endcase
  end

  // Undefined load codes fall back to a full-word load.
  always_comb begin
    w_load = m_rdata;
    case (m_ldtype)
      C_LD_LH:  w_load = {{16{w_half[15]}}, w_half};
      C_LD_LHU: w_load = {16'h0000, w_half};
      C_LD_LB:  w_load = {{24{w_byte[7]}}, w_byte};
      C_LD_LBU: w_load = {24'h000000, w_byte};
      default:  w_load = m_rdata;
    endcase
  end

  always_comb begin
    w_fmt = 32'h0;
    case (m_wbsel)
      C_WB_ALU:  w_fmt = m_alu;
      C_WB_LOAD: w_fmt = w_load;
      C_WB_LINK: w_fmt = m_pc + LINK_OFFSET;
      default:   w_fmt = 32'h0;
    endcase
  end

  // $0 is hardwired zero, and an illegal select must never reach the RF.
  assign w_we_next = m_valid && m_regwrite && (m_wr != 5'd0) && (m_wbsel != C_WB_ILL);

  // Flush wins over stall; a flush loads a bubble rather than the MEM slot.
  assign w_capture = !stall && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we    <= 1'b0;
      r_wr    <= 5'd0;
      r_wd    <= 32'h0;
      r_pc    <= 32'h0;
      r_valid <= 1'b0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else if (flush) begin
      r_we    <= 1'b0;
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_we    <= w_we_next;
      r_wr    <= m_wr;
      r_wd    <= w_fmt;
      r_pc    <= m_pc;
      r_valid <= m_valid;
      if (m_valid) begin
        r_count <= r_count + C_ONE;
      end
      if (m_valid && (m_wbsel == C_WB_ILL)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign w_we          = r_we;
  assign w_wr          = r_wr;
  assign w_wd          = r_wd;
  assign w_pc          = r_pc;
  assign w_valid       = r_valid;
  assign retired_count = r_count;
  assign wb_err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mem_wb_stage                                               |
// | Purpose  : Self-checking bench for mem_wb_stage: directed vector table,  |
// |            hand sequences (stall/flush, illegal select, counter wrap,    |
// |            async reset) and randomized traffic against a reference model.|
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, m_valid, m_regwrite;
  logic [31:0] m_pc, m_alu, m_rdata;
  logic [1:0]  m_addr_lo, m_wbsel;
  logic [4:0]  m_wr;
  logic [2:0]  m_ldtype;

  logic        w_we, w_valid, wb_err;
  logic [4:0]  w_wr;
  logic [31:0] w_wd, w_pc, retired_count;

  logic        w4_we, w4_valid, w4_err;
  logic [4:0]  w4_wr;
  logic [31:0] w4_wd, w4_pc;
  logic [3:0]  w4_count;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic        e_valid, e_we, e_err, e_known;
  logic [4:0]  e_wr;
  logic [31:0] e_wd, e_pc, e_cnt;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .m_valid(m_valid), .m_pc(m_pc), .m_alu(m_alu), .m_rdata(m_rdata),
    .m_addr_lo(m_addr_lo), .m_wr(m_wr), .m_regwrite(m_regwrite),
    .m_wbsel(m_wbsel), .m_ldtype(m_ldtype),
    .w_we(w_we), .w_wr(w_wr), .w_wd(w_wd), .w_pc(w_pc), .w_valid(w_valid),
    .retired_count(retired_count), .wb_err(wb_err)
  );

  mem_wb_stage #(.COUNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .m_valid(m_valid), .m_pc(m_pc), .m_alu(m_alu), .m_rdata(m_rdata),
    .m_addr_lo(m_addr_lo), .m_wr(m_wr), .m_regwrite(m_regwrite),
    .m_wbsel(m_wbsel), .m_ldtype(m_ldtype),
    .w_we(w4_we), .w_wr(w4_wr), .w_wd(w4_wd), .w_pc(w4_pc), .w_valid(w4_valid),
    .retired_count(w4_count), .wb_err(w4_err)
  );

  typedef struct {
    logic        valid;
    logic        regwrite;
    logic [1:0]  wbsel;
    logic [2:0]  ldtype;
    logic [1:0]  lo;
    logic [4:0]  wr;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic        exp_valid;
    logic        exp_we;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Writeback value straight from the load/select rules using integer arithmetic.
  function automatic logic [31:0] model_fmt(input logic [31:0] pc, input logic [31:0] alu,
                                            input logic [31:0] rdata, input logic [1:0] lo,
                                            input logic [1:0] wbsel, input logic [2:0] ldtype);
    longint unsigned b, h;
    b = (longint'(rdata) >> (8 * int'(lo))) % 256;
    h = (lo >= 2) ? (longint'(rdata) >> 16) : (longint'(rdata) % 65536);
    if (wbsel == 2'd0) return alu;
    if (wbsel == 2'd2) return 32'((longint'(pc) + 8) % 64'h1_0000_0000);
    if (wbsel == 2'd3) return 32'h0;
    case (ldtype)
      3'd1:    return (h >= 32768) ? 32'(h + 64'hFFFF_0000) : 32'(h);
      3'd2:    return 32'(h);
      3'd3:    return (b >= 128) ? 32'(b + 64'hFFFF_FF00) : 32'(b);
      3'd4:    return 32'(b);
      default: return rdata;
    endcase
  endfunction

  task automatic model_reset();
    e_valid = 0; e_we = 0; e_err = 0; e_known = 1;
    e_wr = 0; e_wd = 0; e_pc = 0; e_cnt = 0;
  endtask

  task automatic model_edge();
    if (flush) begin
      e_valid = 0; e_we = 0; e_known = 0;
    end else if (!stall) begin
      e_valid = m_valid;
      e_wr    = m_wr;
      e_pc    = m_pc;
      e_wd    = model_fmt(m_pc, m_alu, m_rdata, m_addr_lo, m_wbsel, m_ldtype);
      e_we    = m_valid && m_regwrite && (m_wr != 0) && (m_wbsel != 2'd3);
      e_known = 1;
      if (m_valid) e_cnt = e_cnt + 1;
      if (m_valid && m_wbsel == 2'd3) e_err = 1;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_valid"}, {31'b0, w_valid}, {31'b0, e_valid});
    chk({tag, "_we"},    {31'b0, w_we},    {31'b0, e_we});
    chk({tag, "_err"},   {31'b0, wb_err},  {31'b0, e_err});
    chk({tag, "_cnt"},   retired_count,    e_cnt);
    chk({tag, "_cnt4"},  {28'b0, w4_count}, {28'b0, e_cnt[3:0]});
    if (e_known) begin
      chk({tag, "_wr"}, {27'b0, w_wr}, {27'b0, e_wr});
      chk({tag, "_wd"}, w_wd, e_wd);
      chk({tag, "_pc"}, w_pc, e_pc);
    end
  endtask

  task automatic set_in(input logic v, input logic rw, input logic [1:0] sel,
                        input logic [2:0] lt, input logic [1:0] lo, input logic [4:0] wr,
                        input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rd);
    m_valid = v; m_regwrite = rw; m_wbsel = sel; m_ldtype = lt; m_addr_lo = lo;
    m_wr = wr; m_pc = pc; m_alu = alu; m_rdata = rd;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    //            v  rw sel    lt    lo    wr  pc            alu           rdata         ev ewe exp_wd
    vecs[0]  = '{1, 1, 2'b01, 3'd3, 2'd2, 8,  32'h100,      32'h0,        32'h12803456, 1, 1, 32'hFFFFFF80};
    vecs[1]  = '{1, 1, 2'b01, 3'd4, 2'd2, 8,  32'h104,      32'h0,        32'h12803456, 1, 1, 32'h00000080};
    vecs[2]  = '{1, 1, 2'b01, 3'd1, 2'd2, 9,  32'h108,      32'h0,        32'h9ABC1234, 1, 1, 32'hFFFF9ABC};
    vecs[3]  = '{1, 1, 2'b01, 3'd2, 2'd0, 9,  32'h10C,      32'h0,        32'h9ABC1234, 1, 1, 32'h00001234};
    vecs[4]  = '{1, 1, 2'b10, 3'd0, 2'd0, 31, 32'h00003000, 32'h0,        32'h0,        1, 1, 32'h00003008};
    vecs[5]  = '{1, 1, 2'b10, 3'd0, 2'd0, 31, 32'hFFFFFFFC, 32'h0,        32'h0,        1, 1, 32'h00000004};
    vecs[6]  = '{1, 1, 2'b00, 3'd0, 2'd0, 3,  32'h110,      32'h0000000A, 32'h0,        1, 1, 32'h0000000A};
    vecs[7]  = '{1, 1, 2'b00, 3'd0, 2'd0, 0,  32'h114,      32'h00000055, 32'h0,        1, 0, 32'h00000055};
    vecs[8]  = '{1, 1, 2'b01, 3'd0, 2'd3, 4,  32'h118,      32'h0,        32'hDEADBEEF, 1, 1, 32'hDEADBEEF};
    vecs[9]  = '{1, 1, 2'b01, 3'd7, 2'd1, 4,  32'h11C,      32'h0,        32'hCAFEF00D, 1, 1, 32'hCAFEF00D};
    vecs[10] = '{1, 1, 2'b01, 3'd1, 2'd3, 5,  32'h120,      32'h0,        32'h80007FFF, 1, 1, 32'hFFFF8000};
    vecs[11] = '{0, 1, 2'b00, 3'd0, 2'd0, 6,  32'h124,      32'h77,       32'h0,        0, 0, 32'h00000077};

    stall = 0; flush = 0;
    set_in(1, 1, 2'b00, 3'd0, 2'd0, 5'd7, 32'h55, 32'h66, 32'h77);
    reset = 1'b0;
    model_reset();
    #1;
    check_all("reset0");
    do_reset();
    check_all("reset1");

    // directed table
    for (int i = 0; i < 12; i++) begin
      set_in(vecs[i].valid, vecs[i].regwrite, vecs[i].wbsel, vecs[i].ldtype, vecs[i].lo,
             vecs[i].wr, vecs[i].pc, vecs[i].alu, vecs[i].rdata);
      tick();
      chk($sformatf("vec%0d_we", i), {31'b0, w_we}, {31'b0, vecs[i].exp_we});
      chk($sformatf("vec%0d_valid", i), {31'b0, w_valid}, {31'b0, vecs[i].exp_valid});
      chk($sformatf("vec%0d_wd", i), w_wd, vecs[i].exp_wd);
      check_all($sformatf("vec%0d", i));
    end

    // capture then stall three cycles with changing inputs
    set_in(1, 1, 2'b00, 3'd0, 2'd0, 5'd12, 32'h200, 32'h0000000A, 32'h0);
    tick();
    chk("stall_pre_wd", w_wd, 32'h0000000A);
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      set_in(1, 1, 2'b00, 3'd0, 2'd0, 5'd13 + 5'(k), 32'h300 + 32'(k), 32'hBEEF0 + 32'(k), 32'h0);
      tick();
      chk($sformatf("stall%0d_wd", k), w_wd, 32'h0000000A);
      chk($sformatf("stall%0d_wr", k), {27'b0, w_wr}, 32'd12);
      check_all($sformatf("stall%0d", k));
    end
    flush = 1;
    tick();
    chk("stflush_valid", {31'b0, w_valid}, 32'd0);
    chk("stflush_we", {31'b0, w_we}, 32'd0);
    check_all("stflush");
    stall = 0; flush = 0;

    // illegal select is sticky until reset
    set_in(1, 1, 2'b11, 3'd0, 2'd0, 5'd9, 32'h400, 32'h1234, 32'h0);
    tick();
    chk("ill_we", {31'b0, w_we}, 32'd0);
    chk("ill_err", {31'b0, wb_err}, 32'd1);
    check_all("ill");
    for (int k = 0; k < 3; k++) begin
      set_in(1, 1, 2'b00, 3'd0, 2'd0, 5'd9, 32'h404, 32'h5678, 32'h0);
      tick();
      chk($sformatf("ill_sticky%0d", k), {31'b0, wb_err}, 32'd1);
    end
    do_reset();
    chk("ill_cleared", {31'b0, wb_err}, 32'd0);

    // counter wrap on the 4-bit instance
    for (int k = 0; k < 17; k++) begin
      set_in(1, k[0], 2'b00, 3'd0, 2'd0, 5'(k), 32'(k * 4), 32'(k), 32'h0);
      tick();
    end
    chk("wrap_cnt4", {28'b0, w4_count}, 32'd1);
    chk("wrap_cnt32", retired_count, 32'd17);
    check_all("wrap");

    // async reset between edges discards the in-flight write
    set_in(1, 1, 2'b00, 3'd0, 2'd0, 5'd20, 32'h500, 32'hABCD, 32'h0);
    tick();
    chk("pre_areset_we", {31'b0, w_we}, 32'd1);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("areset_we", {31'b0, w_we}, 32'd0);
    chk("areset_wd", w_wd, 32'd0);
    chk("areset_cnt", retired_count, 32'd0);
    check_all("areset");
    @(posedge clk);
    #1;
    check_all("areset_hold");
    reset = 1'b1;

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 9) == 0);
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
             ($urandom_range(0, 19) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
             3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
             $urandom, $urandom, $urandom);
      if (i == 250) begin
        stall = 0; flush = 0;
        do_reset();
        check_all("rnd_reset");
      end
      tick();
      check_all($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
